// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared encodings for the SRAM-like bus arbiter
package cpu_bus_pkg;
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_ADDR = 2'd1;
  localparam logic [1:0] ARB_DATA = 2'd2;
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;
endpackage

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: serialises fetch and data requests onto one SRAM-like bus
module sram_like_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  input  logic        inst_cancel,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        stallreq_from_if,
  output logic        stallreq_from_mem
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] state, state_nxt;
  logic       owner, drop, grant, grant_own, starved, addr_hs, done;
  logic [3:0] starve_cnt;
  bus_req_t   req_q, req_in;

  // Data wins unless fetch has been passed over LIMIT times in a row
  function automatic logic pick_owner(input logic ireq, input logic dreq, input logic starve);
    return (dreq && !(ireq && starve)) ? OWNER_DATA : OWNER_INST;
  endfunction

  // Grant decision and next-state logic
  always_comb begin
    starved   = starve_cnt == LIMIT;
    grant     = state == ARB_IDLE && (inst_req || data_req);
    grant_own = pick_owner(inst_req, data_req, starved);
    req_in    = grant_own ? {data_wr, data_size, data_addr, data_wdata}
                          : {inst_wr, inst_size, inst_addr, inst_wdata};
    addr_hs   = state == ARB_ADDR && bus_addr_ok;
    done      = (addr_hs || state == ARB_DATA) && bus_data_ok;
    state_nxt = grant ? ARB_ADDR :
                addr_hs ? (bus_data_ok ? ARB_IDLE : ARB_DATA) :
                state == ARB_ADDR ? ARB_ADDR :
                state == ARB_DATA && !bus_data_ok ? ARB_DATA : ARB_IDLE;
  end

  // FSM, owner and request register; the bus fields are frozen for the whole transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
      owner <= OWNER_INST;
      req_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner <= grant_own;
        req_q <= req_in;
      end
    end
  end

  // Count consecutive data grants that overtook a waiting fetch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_cnt <= '0;
    else if (grant) starve_cnt <= (grant_own == OWNER_DATA && inst_req)
                                  ? (starved ? starve_cnt : starve_cnt + 4'd1) : 4'd0;
  end

  // A flushed fetch keeps its bus slot but its response is swallowed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop <= 1'b0;
    else drop <= state_nxt != ARB_IDLE &&
                 (drop || (inst_cancel && owner == OWNER_INST && state != ARB_IDLE));
  end

  // Bus master side, owner-steered handshakes and stall requests
  always_comb begin
    bus_req           = state == ARB_ADDR;
    {bus_wr, bus_size, bus_addr, bus_wdata} = req_q;
    inst_addr_ok      = addr_hs && owner == OWNER_INST;
    data_addr_ok      = addr_hs && owner == OWNER_DATA;
    inst_data_ok      = done && owner == OWNER_INST && !drop;
    data_data_ok      = done && owner == OWNER_DATA;
    inst_rdata        = inst_data_ok ? bus_rdata : 32'h0;
    data_rdata        = data_data_ok ? bus_rdata : 32'h0;
    stallreq_from_if  = rst && !inst_data_ok &&
                        (inst_req || (owner == OWNER_INST && state != ARB_IDLE && !drop));
    stallreq_from_mem = rst && !data_data_ok &&
                        (data_req || (owner == OWNER_DATA && state != ARB_IDLE));
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed scoreboard bench for the two-port bus arbiter
module tb_sram_like_arbiter;
  import cpu_bus_pkg::*;

  logic        clk = 1'b0, rst = 1'b0;
  logic        inst_req = 0, inst_wr = 0, inst_cancel = 0;
  logic [1:0]  inst_size = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 0, data_wr = 0;
  logic [1:0]  data_size = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok = 0, bus_data_ok = 0;
  logic [31:0] bus_rdata = 0;
  logic        stallreq_from_if, stallreq_from_mem;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        own;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;
  txn_t sb[$];
  txn_t dcopy;

  sram_like_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_cancel(inst_cancel), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata),
    .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req_data(input logic [31:0] a, input logic w, input logic [1:0] s,
                          input logic [31:0] wd, input logic [31:0] rd);
    data_addr = a; data_wr = w; data_size = s; data_wdata = wd; data_req = 1'b1;
    sb.push_back({OWNER_DATA, w, s, a, wd, rd});
  endtask

  task automatic req_inst(input logic [31:0] a, input logic [31:0] rd);
    inst_addr = a; inst_wr = 1'b0; inst_size = SIZE_WORD; inst_wdata = 32'h0; inst_req = 1'b1;
    sb.push_back({OWNER_INST, 1'b0, SIZE_WORD, a, 32'h0, rd});
  endtask

  task automatic done_chk(input txn_t t);
    chk("own_data_ok", t.own ? data_data_ok : inst_data_ok, 1);
    chk("own_rdata", t.own ? data_rdata : inst_rdata, t.rdata);
    chk("oth_data_ok", t.own ? inst_data_ok : data_data_ok, 0);
    chk("oth_rdata", t.own ? inst_rdata : data_rdata, 0);
    chk("own_stall_done", t.own ? stallreq_from_mem : stallreq_from_if, 0);
  endtask

  // Slave side for the oldest expected transaction: aw/dw wait cycles, same = one-cycle completion
  task automatic serve(input bit keep, input bit same, input int aw, input int dw, input int lat);
    txn_t t;
    int w;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    t = sb.pop_front();
    @(negedge clk);
    w = 0;
    while (!bus_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("bus_req", bus_req, 1);
    if (lat >= 0) chk("grant_lat", w, lat);
    chk("bus_addr", bus_addr, t.addr);
    chk("bus_wr", bus_wr, t.wr);
    chk("bus_size", bus_size, t.size);
    chk("bus_wdata", bus_wdata, t.wdata);
    for (int i = 0; i < aw; i++) begin
      if (t.own) begin
        data_addr = ~t.addr;
        data_wdata = ~t.wdata;
      end else inst_addr = ~t.addr;
      #1 chk("own_addr_ok_early", t.own ? data_addr_ok : inst_addr_ok, 0);
      @(negedge clk);
      chk("addr_stable", bus_addr, t.addr);
      chk("wdata_stable", bus_wdata, t.wdata);
      chk("req_hold", bus_req, 1);
    end
    bus_addr_ok = 1'b1;
    bus_data_ok = same;
    bus_rdata = same ? t.rdata : 32'h0;
    #1;
    chk("own_addr_ok", t.own ? data_addr_ok : inst_addr_ok, 1);
    chk("oth_addr_ok", t.own ? inst_addr_ok : data_addr_ok, 0);
    if (same) done_chk(t);
    @(negedge clk);
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata = 32'h0;
    if (!keep) begin
      if (t.own) data_req = 1'b0;
      else inst_req = 1'b0;
    end
    if (!same) begin
      for (int i = 0; i < dw; i++) begin
        #1;
        chk("own_data_ok_early", t.own ? data_data_ok : inst_data_ok, 0);
        chk("own_stall_wait", t.own ? stallreq_from_mem : stallreq_from_if, 1);
        chk("bus_req_data", bus_req, 0);
        @(negedge clk);
      end
      bus_data_ok = 1'b1;
      bus_rdata = t.rdata;
      #1 done_chk(t);
      @(negedge clk);
      bus_data_ok = 1'b0;
      bus_rdata = 32'h0;
    end
    #1 chk("idle_gap", bus_req, 0);
  endtask

  initial begin
    // reset holds every output low even with both masters requesting
    #2;
    inst_req = 1'b1;
    data_req = 1'b1;
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_stall_if", stallreq_from_if, 0);
    chk("rst_stall_mem", stallreq_from_mem, 0);
    inst_req = 1'b0;
    data_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // single word read on the data port
    req_data(32'h1FC0_0010, 1'b0, SIZE_WORD, 32'h0, 32'hDEAD_BEEF);
    #1 chk("t1_stall_mem", stallreq_from_mem, 1);
    serve(0, 0, 1, 1, 0);

    // simultaneous requests: data first, fetch on the following IDLE cycle
    req_data(32'h8000_0000, 1'b0, SIZE_WORD, 32'h0, 32'h1111_2222);
    req_inst(32'hBFC0_0000, 32'h3333_4444);
    #1 chk("t2_stall_if", stallreq_from_if, 1);
    serve(0, 0, 0, 0, 0);
    serve(0, 0, 0, 1, 0);

    // byte write with master inputs changing during ADDR
    req_data(32'hA000_0040, 1'b1, SIZE_BYTE, 32'h0000_00A5, 32'h0);
    serve(0, 0, 2, 0, 0);

    // starvation: four data grants overtake the fetch, then the fetch goes
    chk("t3_cnt_start", dut.starve_cnt, 0);
    req_data(32'h8000_1000, 1'b0, SIZE_HALF, 32'h0, 32'h5555_0005);
    dcopy = sb[0];
    repeat (3) sb.push_back(dcopy);
    req_inst(32'hBFC0_0100, 32'h6666_0006);
    sb.push_back(dcopy);
    repeat (4) serve(1, 0, 0, 0, 0);
    chk("t3_cnt_sat", dut.starve_cnt, 4);
    serve(0, 0, 0, 0, 0);
    chk("t3_cnt_clr", dut.starve_cnt, 0);
    serve(0, 0, 0, 0, 0);

    // cancelled fetch: bus completes but no response reaches the fetch port
    inst_addr = 32'hBFC0_0200;
    inst_req = 1'b1;
    @(negedge clk);
    chk("t4_bus_req", bus_req, 1);
    chk("t4_bus_addr", bus_addr, 32'hBFC0_0200);
    bus_addr_ok = 1'b1;
    #1 chk("t4_addr_ok", inst_addr_ok, 1);
    @(negedge clk);
    bus_addr_ok = 1'b0;
    inst_req = 1'b0;
    inst_cancel = 1'b1;
    #1 chk("t4_stall_pre", stallreq_from_if, 1);
    @(negedge clk);
    inst_cancel = 1'b0;
    #1 chk("t4_stall_post", stallreq_from_if, 0);
    bus_data_ok = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    #1;
    chk("t4_no_data_ok", inst_data_ok, 0);
    chk("t4_no_rdata", inst_rdata, 0);
    chk("t4_data_port", data_data_ok, 0);
    @(negedge clk);
    bus_data_ok = 1'b0;
    bus_rdata = 32'h0;
    #1 chk("t4_idle", bus_req, 0);
    req_inst(32'hBFC0_0204, 32'h7777_0007);
    serve(0, 0, 0, 1, 0);

    // same-cycle addr_ok and data_ok on both ports
    req_data(32'h1FC0_0020, 1'b0, SIZE_WORD, 32'h0, 32'hABCD_0123);
    serve(0, 1, 0, 0, 0);
    req_inst(32'hBFC0_0300, 32'h0BAD_F00D);
    serve(0, 1, 0, 0, 0);

    // asynchronous reset while in DATA
    data_addr = 32'h1FC0_0030;
    data_req = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    inst_req = 1'b1;
    #2;
    rst = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata = 32'h1234_5678;
    #1;
    chk("t6_bus_req", bus_req, 0);
    chk("t6_bus_addr", bus_addr, 0);
    chk("t6_data_ok", data_data_ok, 0);
    chk("t6_rdata", data_rdata, 0);
    chk("t6_stall_mem", stallreq_from_mem, 0);
    chk("t6_stall_if", stallreq_from_if, 0);
    data_req = 1'b0;
    inst_req = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    req_data(32'h1FC0_0040, 1'b0, SIZE_WORD, 32'h0, 32'h9999_8888);
    serve(0, 0, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-to-one arbiter placed between the CPU kernel's instruction-fetch and data-memory ports and the single SRAM-like bus to the cache/AXI bridge. It serialises IF and MEM transactions, one outstanding at a time. It generates the `stallreq_from_if` / `stallreq_from_mem` signals consumed by the datapath hazard logic. Data wins by default, and an age counter prevents fetch starvation.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants while fetch waits before fetch is forced ahead once (1–15).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `inst_req`/`data_req` in 1: request, held until the matching `*_addr_ok`.
- `inst_wr`/`data_wr` in 1: write (`inst_wr` expected 0, passed through).
- `inst_size`/`data_size` in 2: 0=byte, 1=half, 2=word.
- `inst_addr`/`data_addr` in 32: physical address.
- `inst_wdata`/`data_wdata` in 32: write data.
- `inst_cancel` in 1: fetch flushed; drop the pending fetch response.
- `inst_addr_ok`/`data_addr_ok` out 1: request accepted (1-cycle pulse).
- `inst_data_ok`/`data_data_ok` out 1: response (1-cycle pulse).
- `inst_rdata`/`data_rdata` out 32: read data, valid with `*_data_ok`.
- `bus_req` out 1; `bus_wr` out 1; `bus_size` out 2; `bus_addr` out 32; `bus_wdata` out 32: master side.
- `bus_addr_ok` in 1; `bus_data_ok` in 1; `bus_rdata` in 32: slave handshake.
- `stallreq_from_if` out 1; `stallreq_from_mem` out 1: pipeline stall requests.

## Operation
- FSM states: IDLE, ADDR, DATA. Owner register: INST or DATA.
- **IDLE**
  - No request: stay in IDLE.
  - Otherwise grant and latch owner, wr, size, addr, wdata into the request register, then go to ADDR.
  - If both request, DATA wins unless `starve_cnt == STARVE_LIMIT`, in which case INST wins.
- **ADDR**
  - `bus_req=1`; bus fields come from the request register.
  - On `bus_addr_ok`: pulse owner `*_addr_ok`, go to DATA.
  - If `bus_data_ok` arrives in the same cycle as `bus_addr_ok`: complete immediately and go to IDLE.
- **DATA**
  - `bus_req=0`.
  - On `bus_data_ok`: pulse owner `*_data_ok`, forward `bus_rdata` combinationally to owner `*_rdata`, go to IDLE.
- **Starvation counter `starve_cnt`** (4 bits):
  - +1 on each DATA grant while `inst_req` is high.
  - Cleared on any INST grant or when `inst_req` is low at grant time.
  - Saturates at `STARVE_LIMIT`.
- **Cancel**
  - `inst_cancel` while owner=INST in ADDR or DATA sets the `drop` flag.
  - The bus transaction still completes, but `inst_data_ok` is suppressed.
  - `drop` clears on return to IDLE.
  - `inst_cancel` in IDLE or with owner=DATA has no effect.
- **Stall requests**
  - `stallreq_from_if = inst_req | (owner==INST & state!=IDLE & !drop)`, deasserted in the cycle `inst_data_ok` pulses.
  - `stallreq_from_mem` is the same rule with `data_*` and no drop.
- Non-owner `*_addr_ok` / `*_data_ok` are always 0.
- `*_rdata` is 0 whenever its `*_data_ok` is 0.

## Timing
- Reset (async, `rst=0`):
  - State goes to IDLE; owner, `drop` and `starve_cnt` clear to 0.
  - All outputs drop to 0 immediately: `bus_req`, `bus_addr`, `bus_wdata`, `*_ok`, `*_rdata`, and both stall outputs.
  - Reset asserted mid-transaction abandons it; slave cleanup is the bus owner's responsibility.
- Grant latency: request seen in IDLE at cycle N gives `bus_req` at N+1.
- Minimum transaction: 3 cycles (IDLE→ADDR with same-cycle addr_ok+data_ok→IDLE).
- Back-to-back transactions have one IDLE cycle between them.
- `bus_*` fields are stable for the whole of ADDR regardless of master input changes.

## Structure
- Shared package `cpu_bus_pkg`:
  - FSM state encoding: `ARB_IDLE=2'd0`, `ARB_ADDR=2'd1`, `ARB_DATA=2'd2`.
  - `OWNER_INST=1'b0`, `OWNER_DATA=1'b1`.
  - Size codes.
- Single module, no sub-modules.
  - Request register is 1+2+32+32 bits plus owner.
  - Priority logic is a small combinational function.

## Test plan
- **Single word read, data port**:
  - `data_req`, addr 0x1FC0_0010 at cycle 0.
  - Slave addr_ok at cycle 2, data_ok with 0xDEAD_BEEF at cycle 4.
  - Expect `bus_req` high cycles 1–2, `data_addr_ok` at 2, `data_data_ok`+rdata 0xDEAD_BEEF at 4, `stallreq_from_mem` low from 4.
- **Simultaneous requests**:
  - Inst 0xBFC0_0000 and data 0x8000_0000 both requested.
  - Data served first; inst granted on the IDLE cycle after `data_data_ok`.
- **Starvation**:
  - `STARVE_LIMIT=4`; inst held high while data requests continuously.
  - Exactly 4 data grants, then an inst grant, then `starve_cnt=0`.
- **Cancel**:
  - Inst fetch in DATA state; `inst_cancel` pulsed 1 cycle before `bus_data_ok`.
  - No `inst_data_ok`; `stallreq_from_if` low after cancel (inst_req low); next request granted normally.
- **Same-cycle ok**:
  - `bus_addr_ok` and `bus_data_ok` both high in the first ADDR cycle.
  - Both owner pulses in the same cycle; FSM returns to IDLE next cycle.
- **Reset mid-operation**:
  - `rst=0` asynchronously while in DATA.
  - `bus_req` and all oks/stalls are 0 before the next edge; after release, a new read completes normally.
